// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - round-robin time-share of one 16-bit hex display among four sources
module hex_display_arbiter #(
  parameter int NREQ         = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   src_data,
  input  logic                 freeze,
  output logic [15:0]          disp_data,
  output logic [NREQ-1:0]      grant,
  output logic                 disp_valid,
  output logic                 switch_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   grant_d;
  logic [15:0]       disp_d;
  logic              pulse_d;

  logic              found;
  logic [1:0]        sel;
  logic [1:0]        owner;
  logic              expired;

  // Circular search from ptr; scanning offsets high-to-low lets the nearest hit win.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        found = 1'b1;
        sel   = ptr_q + 2'(k);
      end
    end
  end

  // Index of the current owner, recovered from the one-hot grant.
  always_comb begin
    owner = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) owner = 2'(i);
    end
  end

  assign expired    = (cnt_q == CNT_MAX);
  assign disp_valid = |grant;

  // Next-state and next-output logic; every register holds unless a branch says otherwise.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant;
    disp_d  = disp_data;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SHOW;
          grant_d = NREQ'(1) << sel;
          disp_d  = src_data[{sel, 4'b0000} +: 16];
          pulse_d = 1'b1;
          cnt_d   = '0;
          ptr_d   = sel + 2'd1;
        end
      end
      SHOW: begin
        if (expired && !freeze) begin
          if (!found) begin
            state_d = IDLE;
            grant_d = '0;
          end else begin
            cnt_d  = '0;
            ptr_d  = sel + 2'd1;
            disp_d = src_data[{sel, 4'b0000} +: 16];
            if (sel != owner) begin
              grant_d = NREQ'(1) << sel;
              pulse_d = 1'b1;
            end
          end
        end else begin
          // Live tracking of the owner; a dropped request freezes the shown word.
          if (req[owner]) disp_d = src_data[{owner, 4'b0000} +: 16];
          if (!expired) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      cnt_q        <= '0;
      grant        <= '0;
      disp_data    <= 16'h0000;
      switch_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      grant        <= grant_d;
      disp_data    <= disp_d;
      switch_pulse <= pulse_d;
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb/tb_hex_display_arbiter.sv - scoreboard bench for hex_display_arbiter
module tb_hex_display_arbiter;

  localparam int DWELL = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] src_data;
  logic        freeze;
  logic [15:0] disp_data;
  logic [3:0]  grant;
  logic        disp_valid;
  logic        switch_pulse;

  hex_display_arbiter #(.NREQ(4), .DWELL_CYCLES(DWELL), .CNT_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .src_data     (src_data),
    .freeze       (freeze),
    .disp_data    (disp_data),
    .grant        (grant),
    .disp_valid   (disp_valid),
    .switch_pulse (switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  g;
    logic [15:0] d;
    logic        p;
    logic        v;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] src_w [4];

  bit          m_show;
  int          m_ptr, m_cnt, m_owner;
  logic [3:0]  m_grant;
  logic [15:0] m_disp;
  logic        m_pulse;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_show = 0; m_ptr = 0; m_cnt = 0; m_owner = 0;
    m_grant = 4'b0; m_disp = 16'h0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic f);
    int  pick;
    bit  hit;
    hit  = 0;
    pick = 0;
    for (int k = 0; k < 4; k++) begin
      if (!hit && r[(m_ptr + k) % 4]) begin
        hit  = 1;
        pick = (m_ptr + k) % 4;
      end
    end
    m_pulse = 1'b0;
    if (!m_show) begin
      if (hit) begin
        m_show = 1; m_owner = pick; m_grant = 4'(1 << pick);
        m_disp = src_w[pick]; m_pulse = 1'b1; m_cnt = 0; m_ptr = (pick + 1) % 4;
      end
    end else if (m_cnt == DWELL - 1 && !f) begin
      if (!hit) begin
        m_show = 0; m_grant = 4'b0;
      end else begin
        if (pick != m_owner) m_pulse = 1'b1;
        m_owner = pick; m_grant = 4'(1 << pick); m_disp = src_w[pick];
        m_cnt = 0; m_ptr = (pick + 1) % 4;
      end
    end else begin
      if (r[m_owner]) m_disp = src_w[m_owner];
      if (m_cnt < DWELL - 1) m_cnt++;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic f);
    exp_t e;
    req      = r;
    freeze   = f;
    src_data = {src_w[3], src_w[2], src_w[1], src_w[0]};
    model_step(r, f);
    sb_q.push_back('{g: m_grant, d: m_disp, p: m_pulse, v: |m_grant});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("grant",        32'(grant),        32'(e.g));
    check_eq("disp_data",    32'(disp_data),    32'(e.d));
    check_eq("switch_pulse", 32'(switch_pulse), 32'(e.p));
    check_eq("disp_valid",   32'(disp_valid),   32'(e.v));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check_eq({tag, "_grant"}, 32'(grant),        32'h0);
    check_eq({tag, "_disp"},  32'(disp_data),    32'h0);
    check_eq({tag, "_valid"}, 32'(disp_valid),   32'h0);
    check_eq({tag, "_pulse"}, 32'(switch_pulse), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; req = 4'b0; freeze = 1'b0; src_data = 64'h0;
    for (int i = 0; i < 4; i++) src_w[i] = 16'h0;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("por_grant", 32'(grant),     32'h0);
    check_eq("por_disp",  32'(disp_data), 32'h0);
    reset = 1'b1;

    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Single requester: pulse once, then silent re-grants every dwell.
    src_w[1] = 16'hBEEF;
    step(4'b0010, 1'b0);
    check_eq("single_first_grant", 32'(grant), 32'h2);
    check_eq("single_first_disp",  32'(disp_data), 32'hBEEF);
    for (int i = 0; i < 11; i++) step(4'b0010, 1'b0);

    // Round-robin over all four sources.
    do_reset("rst_rr");
    for (int i = 0; i < 4; i++) src_w[i] = 16'h1111 * 16'(i + 1);
    for (int i = 0; i < 20; i++) begin
      step(4'b1111, 1'b0);
      if (i % 4 == 0) check_eq("rr_disp_step", 32'(disp_data), 32'h1111 * 32'((i / 4) % 4 + 1));
    end

    // Owner drops its request: displayed word holds, then arbitration moves on or idles.
    do_reset("rst_drop");
    src_w[0] = 16'h00A5;
    step(4'b0001, 1'b0);
    src_w[0] = 16'h5A00;
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0);
    check_eq("drop_idle_disp", 32'(disp_data), 32'h00A5);
    src_w[0] = 16'h00A5;
    src_w[2] = 16'h2C2C;
    step(4'b0001, 1'b0);
    src_w[0] = 16'h5A00;
    for (int i = 0; i < 6; i++) step(4'b0100, 1'b0);

    // Freeze held across expiry, then released.
    do_reset("rst_frz");
    src_w[0] = 16'hF000; src_w[1] = 16'hF001;
    step(4'b0011, 1'b0);
    for (int i = 0; i < 23; i++) step(4'b0011, 1'b1);
    check_eq("frz_hold_grant", 32'(grant), 32'h1);
    step(4'b0011, 1'b0);
    check_eq("frz_release_grant", 32'(grant), 32'h2);
    check_eq("frz_release_pulse", 32'(switch_pulse), 32'h1);
    for (int i = 0; i < 6; i++) step(4'b0011, 1'b0);

    // Live tracking of an incrementing source, then reset mid-dwell.
    do_reset("rst_live");
    src_w[2] = 16'h0100;
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, 1'b0);
      src_w[2] = src_w[2] + 16'd1;
    end
    check_eq("live_grant", 32'(grant), 32'h4);
    do_reset("rst_mid_show");
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      for (int j = 0; j < 4; j++) src_w[j] = 16'($urandom);
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
